// File: rtl/fetch_byte_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_byte_queue
// Purpose  : Fetch-stage prefetch queue between the icache and the decoder.
//            Issues 16B-aligned line requests, holds two returned lines and
//            presents a byte-aligned 16-byte window starting at the current
//            EIP. The decoder retires 1..15 bytes per cycle. A redirect
//            flushes the queue and restarts fetch at the new target.
// Ports    : clk, reset (async, active-high)
//            redirect_valid/redirect_addr  - new fetch target
//            req_valid/req_ready/req_address - icache line request
//            dp_valid/dp_ready/dp_read_data  - icache line data return
//            dec_valid/dec_bytes/dec_count/dec_eip - decoder window
//            dec_consume/dec_len            - decoder byte retirement
// Revision : 1.0 - initial release
// ============================================================================
module fetch_byte_queue #(
  parameter int IDATAW = 128,
  parameter int IADDRW = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              redirect_valid,
  input  logic [IADDRW-1:0] redirect_addr,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [IADDRW-1:0] req_address,
  input  logic              dp_valid,
  output logic              dp_ready,
  input  logic [IDATAW-1:0] dp_read_data,
  output logic              dec_valid,
  output logic [IDATAW-1:0] dec_bytes,
  output logic [4:0]        dec_count,
  output logic [IADDRW-1:0] dec_eip,
  input  logic              dec_consume,
  input  logic [3:0]        dec_len
);

  localparam int NBYTES = IDATAW / 8;

  // Queue state
  logic [1:0][IDATAW-1:0] slot_data;
  logic [1:0]             slot_valid;
  logic                   oldest;       // index of the slot holding EIP
  logic [3:0]             head;         // byte offset of EIP in oldest slot
  logic [IADDRW-1:0]      eip;
  logic [IADDRW-1:0]      fetch_addr;
  logic                   started;
  logic                   outstanding;
  logic                   drop;         // one stale response still due

  // Combinational helpers
  logic [1:0]        valid_cnt;
  logic [5:0]        avail;
  logic              fill_slot;
  logic              req_fire;
  logic              dp_fire;
  logic              fill_accept;
  logic              consume_ok;
  logic [4:0]        head_sum;
  logic [1:0]        slot_valid_next;
  logic [IDATAW-1:0] older_line;
  logic [IDATAW-1:0] newer_line;
  logic [IDATAW-1:0] window;
  logic [4:0]        byte_idx;

  assign valid_cnt = {slot_valid[0] & slot_valid[1], slot_valid[0] ^ slot_valid[1]};

  // With no valid slot head may be non-zero (pending first line after a
  // redirect), so the byte count is forced to zero instead of going negative.
  assign avail = (valid_cnt == 2'd0) ? 6'd0
                                     : ({valid_cnt, 4'b0000} - {2'b00, head});

  assign dec_count = (avail > 6'd16) ? 5'd16 : avail[4:0];
  assign dec_valid = (avail != 6'd0);
  assign dec_eip   = eip;

  // When only one slot is valid it is always the oldest one, so the free
  // slot is the oldest when empty and the other one otherwise.
  assign fill_slot = slot_valid[oldest] ? ~oldest : oldest;

  assign req_valid   = started & ~outstanding & ~drop & ~(&slot_valid) & ~redirect_valid;
  assign req_address = fetch_addr;
  assign req_fire    = req_valid & req_ready;

  assign dp_ready    = outstanding | drop;
  assign dp_fire     = dp_valid & dp_ready;
  assign fill_accept = dp_fire & ~drop;

  assign consume_ok = dec_consume & (dec_len != 4'd0) & ({1'b0, dec_len} <= dec_count);
  assign head_sum   = {1'b0, head} + {1'b0, dec_len};

  // A consume that crosses the line end frees the oldest slot; a fill never
  // targets that same slot because the oldest slot is valid whenever a
  // consume can happen.
  always_comb begin
    slot_valid_next = slot_valid;
    if (consume_ok && head_sum[4]) begin
      slot_valid_next[oldest] = 1'b0;
    end
    if (fill_accept) begin
      slot_valid_next[fill_slot] = 1'b1;
    end
  end

  assign older_line = slot_data[oldest];
  assign newer_line = slot_data[~oldest];

  // Window byte i comes from offset head+i of the older line, spilling into
  // the newer line once the offset passes the line end.
  always_comb begin
    window   = '0;
    byte_idx = '0;
    for (int i = 0; i < NBYTES; i++) begin
      byte_idx = {1'b0, head} + 5'(i);
      if (byte_idx[4]) begin
        window[8*i +: 8] = newer_line[{byte_idx[3:0], 3'b000} +: 8];
      end else begin
        window[8*i +: 8] = older_line[{byte_idx[3:0], 3'b000} +: 8];
      end
    end
  end

  assign dec_bytes = window;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_data   <= '0;
      slot_valid  <= '0;
      oldest      <= 1'b0;
      head        <= '0;
      eip         <= '0;
      fetch_addr  <= '0;
      started     <= 1'b0;
      outstanding <= 1'b0;
      drop        <= 1'b0;
    end else if (redirect_valid) begin
      slot_valid  <= '0;
      eip         <= redirect_addr;
      head        <= redirect_addr[3:0];
      fetch_addr  <= {redirect_addr[IADDRW-1:4], 4'b0000};
      started     <= 1'b1;
      outstanding <= 1'b0;
      // A response still owed by the icache must be swallowed later; one
      // arriving right now is discarded and settles the debt immediately.
      drop        <= dp_ready & ~dp_valid;
    end else begin
      slot_valid <= slot_valid_next;
      if (consume_ok && head_sum[4]) begin
        oldest <= ~oldest;
      end
      if (fill_accept) begin
        slot_data[fill_slot] <= dp_read_data;
      end
      if (consume_ok) begin
        eip  <= eip + IADDRW'(dec_len);
        head <= head_sum[3:0];
      end
      if (req_fire) begin
        outstanding <= 1'b1;
        fetch_addr  <= fetch_addr + IADDRW'(NBYTES);
      end
      if (dp_fire) begin
        if (drop) begin
          drop <= 1'b0;
        end else begin
          outstanding <= 1'b0;
        end
      end
    end
  end

endmodule
`default_nettype wire
